jam_cost_arbiter: RTL

- Shares the single Cost ROM (W/J address in, 7-bit Cost out) among NREQ permutation-search engines, so the 40320-permutation space can be split across engines.
- Round-robin arbitration with an optional lock, so an engine can read all 8 costs of one permutation back-to-back.
- Registers the ROM address and carries a requester tag down a latency pipeline.
- Routes each returned Cost to the engine that issued the read.

---
 rtl/jam_cost_arbiter_pkg.sv | 20 ++
 rtl/jam_cost_arbiter_if.sv | 28 ++
 rtl/jam_cost_arbiter_rr_pick.sv | 33 +++
 rtl/jam_cost_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/jam_cost_arbiter_pkg.sv
// Shared types and widths for the Cost ROM arbiter slice.
//   JAM_IDX_W : width of a worker/job index (W, J)
//   COST_W    : width of one Cost ROM word
//   NREQ_MAX  : largest supported number of requesting engines
package jam_pkg;
  localparam int unsigned JAM_IDX_W = 3;
  localparam int unsigned COST_W    = 7;
  localparam int unsigned NREQ_MAX  = 4;

  typedef enum logic {
    OPEN,
    LOCKED
  } arb_state_t;

  // One slot of the read-latency pipeline: which engine a read belongs to.
  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;
endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine-side bus of the Cost ROM arbiter.
//   req_valid/req_lock/req_w/req_j : per-engine read request (engine i at [3i+2:3i])
//   req_ready                      : one-hot grant back to the engines
//   rsp_valid/rsp_cost             : one-hot response pulse and its Cost word
// master = the engines, slave = the arbiter.
interface jam_cost_arbiter_if
  import jam_pkg::*;
#(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_lock;
  logic [JAM_IDX_W*NREQ-1:0] req_w;
  logic [JAM_IDX_W*NREQ-1:0] req_j;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           rsp_valid;
  logic [COST_W-1:0]         rsp_cost;

  modport master (
    output req_valid, req_lock, req_w, req_j,
    input  req_ready, rsp_valid, rsp_cost
  );

  modport slave (
    input  req_valid, req_lock, req_w, req_j,
    output req_ready, rsp_valid, rsp_cost
  );
endinterface

// File: rtl/jam_cost_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   valid : request vector
//   ptr   : index searched first; search continues ptr+1, ... mod NREQ
//   mask  : requests allowed to win this cycle
//   grant : one-hot winner (zero if nobody eligible)
//   idx   : binary index of the winner
//   any   : a winner exists
module jam_rr_pick #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx,
  output logic            any
);
  always_comb begin
    int unsigned c;
    c     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = (32'(ptr) + k) % NREQ;
      if (!any && valid[c] && mask[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = 2'(c);
      end
    end
  end
endmodule

// File: rtl/jam_cost_arbiter.sv
// Shares one Cost ROM among NREQ permutation-search engines.
//   CLK, RST    : clock, asynchronous active-high reset
//   eng         : engine-side request/response bus (slave modport)
//   W, J        : registered ROM worker/job address
//   Cost        : ROM data, sampled ROM_LAT cycles after W/J update
//   total_reads : count of accepted reads, wrapping
// Round-robin grant, with an optional lock that lets one engine own the
// ROM for up to MAX_BURST consecutive reads. A tag pipeline follows each
// read so the returned Cost is routed back to its issuer.
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  jam_cost_arbiter_if.slave    eng,
  output logic [JAM_IDX_W-1:0] W,
  output logic [JAM_IDX_W-1:0] J,
  input  logic [COST_W-1:0]    Cost,
  output logic [15:0]          total_reads
);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arb_state_t          state, state_nxt;
  logic [1:0]          rr_ptr, rr_ptr_nxt, owner, owner_nxt, pick_idx;
  logic [BW-1:0]       burst_cnt, burst_nxt, burst_inc;
  logic [NREQ-1:0]     owner_oh, pick_mask, grant;
  logic                pick_any, accept_lock, owner_valid;
  logic [JAM_IDX_W-1:0] sel_w, sel_j;
  tag_t [ROM_LAT-1:0]  tag_pipe;
  tag_t                tag_out;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [COST_W-1:0]   rsp_cost_q;

  assign owner_oh    = NREQ'(1) << owner;
  assign pick_mask   = (state == LOCKED) ? owner_oh : '1;
  assign accept_lock = |(eng.req_lock & grant);
  assign owner_valid = |(eng.req_valid & owner_oh);
  assign burst_inc   = burst_cnt + BW'(1);

  jam_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (eng.req_valid),
    .ptr   (rr_ptr),
    .mask  (pick_mask),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign eng.req_ready = grant;

  always_comb begin
    sel_w = '0;
    sel_j = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_w = eng.req_w[i*JAM_IDX_W +: JAM_IDX_W];
        sel_j = eng.req_j[i*JAM_IDX_W +: JAM_IDX_W];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    burst_nxt  = burst_cnt;
    rr_ptr_nxt = rr_ptr;
    if (pick_any)
      rr_ptr_nxt = (pick_idx == 2'(NREQ - 1)) ? 2'd0 : pick_idx + 2'd1;
    unique case (state)
      OPEN: begin
        if (pick_any && accept_lock && (MAX_BURST > 1)) begin
          state_nxt = LOCKED;
          owner_nxt = pick_idx;
          burst_nxt = BW'(1);
        end
      end
      LOCKED: begin
        // An owner that lets valid drop gives the ROM back immediately,
        // so a stalled engine can never starve the others.
        if (!owner_valid || (pick_any && !accept_lock) ||
            (pick_any && burst_inc == BW'(MAX_BURST))) begin
          state_nxt = OPEN;
          burst_nxt = '0;
        end else if (pick_any) begin
          burst_nxt = burst_inc;
        end
      end
      default: state_nxt = OPEN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= OPEN;
      owner       <= '0;
      burst_cnt   <= '0;
      rr_ptr      <= '0;
      W           <= '0;
      J           <= '0;
      total_reads <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
      rr_ptr    <= rr_ptr_nxt;
      if (pick_any) begin
        W           <= sel_w;
        J           <= sel_j;
        total_reads <= total_reads + 16'd1;
      end
    end
  end

  // Slot 0 is written at the accept edge together with W/J, so the last
  // slot is valid exactly when Cost for that address is being presented.
  assign tag_out = tag_pipe[ROM_LAT-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_pipe    <= '0;
      rsp_valid_q <= '0;
      rsp_cost_q  <= '0;
    end else begin
      tag_pipe[0] <= '{valid: pick_any, id: pick_idx};
      for (int unsigned k = 1; k < ROM_LAT; k++)
        tag_pipe[k] <= tag_pipe[k-1];
      if (tag_out.valid) begin
        rsp_valid_q <= NREQ'(1) << tag_out.id;
        rsp_cost_q  <= Cost;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign eng.rsp_valid = rsp_valid_q;
  assign eng.rsp_cost  = rsp_cost_q;
endmodule
